dkong_obj_dma: RTL and testbench
================================

# dkong_obj_dma

Sprite-attribute DMA engine, the stage directly upstream of the object/sprite RAM. On a CPU trigger it requests the CPU bus, copies a fixed-length block from the CPU-side 1024×8 work RAM (synchronous read, 1-cycle latency, output forced to 0 when its CE is low) into the video-side object RAM, then releases the bus. It replaces the original board's 8257 DMA channel.

## Interface
- SRC_AW, 10: source RAM address width.
- DST_AW, 10: destination RAM address width.
- LEN, 384: bytes per transfer; legal range 1 to 2^DST_AW.
- I_CLK in 1: single system clock.
- I_RST in 1: reset, asynchronous, active-high.
- I_CE in 1: clock enable; state, counters and all registers advance only on I_CLK edges with I_CE=1.
- I_START in 1: transfer trigger, level-sampled on CE cycles.
- I_SRC_BASE in SRC_AW: source start address, latched on accepted start.
- I_DST_BASE in DST_AW: destination start address, latched on accepted start.
- O_HALT_REQ out 1: CPU bus hold request.
- I_HALT_ACK in 1: CPU bus grant.
- O_SRC_ADDR out SRC_AW: source read address.
- O_SRC_CE out 1: source read enable.
- I_SRC_D in 8: source read data, valid on the CE cycle after the read.
- O_DST_ADDR out DST_AW, O_DST_D out 8, O_DST_WE out 1: destination write port.
- O_BUSY out 1: high from accepted start until DONE ends.
- O_DONE out 1: one-CE-cycle completion pulse.

## Operation
- States: IDLE, REQ, RUN, DONE.
- IDLE: I_START=1 → latch bases, clear rd_idx/wr_idx → REQ. I_START while not IDLE is ignored; no queuing.
- REQ: O_HALT_REQ=1. I_HALT_ACK=1 → RUN.
- RUN: O_HALT_REQ=1.
  - Read issue: O_SRC_CE=I_HALT_ACK and rd_idx<LEN. O_SRC_ADDR=src_base+rd_idx, modulo 2^SRC_AW. rd_idx increments per issued read.
  - Capture: on the CE cycle after each issued read, I_SRC_D goes into a 1-entry hold register, regardless of I_HALT_ACK.
  - Write: O_DST_WE=I_HALT_ACK and hold register valid. O_DST_ADDR=dst_base+wr_idx, modulo 2^DST_AW. O_DST_D=hold data. wr_idx increments per write.
  - Read and write occur in the same cycle in steady state.
  - wr_idx==LEN → DONE.
- DONE: O_DONE=1, O_BUSY=1, O_HALT_REQ=0. Next CE cycle → IDLE.
- I_HALT_ACK low during RUN freezes issue and write. Bytes are never lost, duplicated or reordered; the captured byte waits in the hold register.
- Counters are wide enough for LEN (clog2(LEN+1) bits).

## Timing
- Reset values: O_HALT_REQ=0, O_SRC_CE=0, O_DST_WE=0, O_BUSY=0, O_DONE=0, O_SRC_ADDR=0, O_DST_ADDR=0, O_DST_D=0. State is IDLE, counters and hold-valid are 0.
- Reset asserted mid-transfer: all outputs drop asynchronously and the transfer is abandoned. The destination keeps the partial contents.
- State, O_HALT_REQ, O_BUSY and O_DONE are registered.
- O_SRC_CE and O_DST_WE are combinational from state, counters, hold-valid and I_HALT_ACK, all gated by I_CE.
- Latencies with I_CE=1 and ack returned in REQ's first cycle (CE cycles, start sampled at cycle 0):
  - HALT_REQ/BUSY rise at 1.
  - First read at 2.
  - Write n at 3+n.
  - Last write at 2+LEN.
  - DONE at 3+LEN.
  - IDLE at 4+LEN.
- Each CE-cycle of ack stall adds one cycle.
- Start asserted continuously retriggers one cycle after DONE (at IDLE).

## Test plan
- Basic copy: LEN=384, src 0x000..0x17F = index^0x5A, SRC_BASE=0x000, DST_BASE=0x000, ack tied high → dst[0x000..0x17F] match, exactly 384 WE pulses, DONE at cycle 387, HALT_REQ low at 387.
- Wrap: LEN=32 override, SRC_BASE=0x3F8, DST_BASE=0x3F0 → src reads 0x3F8..0x3FF then 0x000..0x017; dst writes 0x3F0..0x3FF then 0x000..0x00F, in order.
- Ack stall: deassert I_HALT_ACK for 5 cycles at write 100 and for 1 cycle at write 200 → data intact, no duplicate writes, DONE delayed by exactly 6 cycles.
- CE throttling: I_CE high 1 cycle in 4 → identical dst contents. No output changes on non-CE edges. DONE pulse is exactly one CE cycle wide.
- Reset mid-run: assert I_RST at write 50 → HALT_REQ/WE/BUSY go 0 asynchronously, dst[0..49] written, dst[50..] untouched. A new start afterwards completes normally.
- Start during busy: pulse I_START at write 10 with different bases → ignored. The original transfer completes unchanged, and exactly one DONE pulse occurs.

Source files
------------

// File: rtl/dkong_obj_dma.sv
// dkong_obj_dma: sprite-attribute DMA engine.
// On a start trigger it holds the CPU bus, copies LEN bytes from the CPU work
// RAM (synchronous read, one CE-cycle latency) into the object RAM, then
// releases the bus and pulses O_DONE.
module dkong_obj_dma #(
   parameter int unsigned SRC_AW = 10,
   parameter int unsigned DST_AW = 10,
   parameter int unsigned LEN    = 384
) (
   input  logic              I_CLK,
   input  logic              I_RST,
   input  logic              I_CE,
   input  logic              I_START,
   input  logic [SRC_AW-1:0] I_SRC_BASE,
   input  logic [DST_AW-1:0] I_DST_BASE,
   output logic              O_HALT_REQ,
   input  logic              I_HALT_ACK,
   output logic [SRC_AW-1:0] O_SRC_ADDR,
   output logic              O_SRC_CE,
   input  logic [7:0]        I_SRC_D,
   output logic [DST_AW-1:0] O_DST_ADDR,
   output logic [7:0]        O_DST_D,
   output logic              O_DST_WE,
   output logic              O_BUSY,
   output logic              O_DONE
);

   localparam int unsigned   CW     = $clog2(LEN + 1);
   localparam logic [CW-1:0] LEN_C  = CW'(LEN);
   localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;

   logic [SRC_AW-1:0] src_base_q, src_base_d;
   logic [DST_AW-1:0] dst_base_q, dst_base_d;
   logic [CW-1:0]     rd_idx_q, rd_idx_d;
   logic [CW-1:0]     wr_idx_q, wr_idx_d;
   logic              pend_q, pend_d;     // read issued last CE cycle, data on I_SRC_D now
   logic              hold_v_q, hold_v_d; // captured byte waiting for a write slot
   logic [7:0]        hold_q, hold_d;

   logic              halt_req_q, halt_req_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              rd_issue_c;
   logic              wr_issue_c;

   // Read/write slot qualification; both freeze while the bus grant is withdrawn
   always_comb begin
      rd_issue_c = 1'b0;
      wr_issue_c = 1'b0;
      if (I_CE && (state_q == S_RUN) && I_HALT_ACK) begin
         rd_issue_c = (rd_idx_q < LEN_C);
         wr_issue_c = hold_v_q || pend_q;
      end
   end

   // FSM state register
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q <= S_IDLE;
      end else if (I_CE) begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (I_START) state_d = S_REQ;
         S_REQ:  if (I_HALT_ACK) state_d = S_RUN;
         S_RUN:  if (wr_issue_c && (wr_idx_q == LAST_C)) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: registered bus/status flags follow the next state, strobes are live
   always_comb begin
      halt_req_d = (state_d == S_REQ) || (state_d == S_RUN);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      O_SRC_CE   = rd_issue_c;
      O_DST_WE   = wr_issue_c;
   end

   // Datapath next values: base latch, index counters, capture/hold of read data
   always_comb begin
      src_base_d = src_base_q;
      dst_base_d = dst_base_q;
      rd_idx_d   = rd_idx_q;
      wr_idx_d   = wr_idx_q;
      hold_d     = hold_q;

      if ((state_q == S_IDLE) && I_START) begin
         src_base_d = I_SRC_BASE;
         dst_base_d = I_DST_BASE;
         rd_idx_d   = '0;
         wr_idx_d   = '0;
      end

      if (rd_issue_c) rd_idx_d = rd_idx_q + CW'(1);
      if (wr_issue_c) wr_idx_d = wr_idx_q + CW'(1);

      // Read data is only present for one CE cycle, so it is always captured;
      // it stays valid in the hold register until a write slot consumes it.
      pend_d = rd_issue_c;
      if (pend_q) hold_d = I_SRC_D;
      hold_v_d = (hold_v_q || pend_q) && !wr_issue_c;
   end

   // Datapath and registered output flops
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         src_base_q <= '0;
         dst_base_q <= '0;
         rd_idx_q   <= '0;
         wr_idx_q   <= '0;
         pend_q     <= 1'b0;
         hold_v_q   <= 1'b0;
         hold_q     <= '0;
         halt_req_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (I_CE) begin
         src_base_q <= src_base_d;
         dst_base_q <= dst_base_d;
         rd_idx_q   <= rd_idx_d;
         wr_idx_q   <= wr_idx_d;
         pend_q     <= pend_d;
         hold_v_q   <= hold_v_d;
         hold_q     <= hold_d;
         halt_req_q <= halt_req_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Address generation wraps naturally at the RAM widths; write data bypasses
   // the hold register when the byte arrives in a cycle that can write it
   always_comb begin
      O_SRC_ADDR = src_base_q + SRC_AW'(rd_idx_q);
      O_DST_ADDR = dst_base_q + DST_AW'(wr_idx_q);
      O_DST_D    = pend_q ? I_SRC_D : hold_q;
      O_HALT_REQ = halt_req_q;
      O_BUSY     = busy_q;
      O_DONE     = done_q;
   end

endmodule

// File: tb/tb_dkong_obj_dma.sv
// Testbench for dkong_obj_dma: scoreboard of expected destination writes,
// behavioural source RAM, randomized bases/data/grant/clock-enable.
module tb_dkong_obj_dma;

   localparam int unsigned SRC_AW = 10;
   localparam int unsigned DST_AW = 10;
   localparam int unsigned LEN    = 384;
   localparam int unsigned SRC_N  = 1 << SRC_AW;
   localparam int unsigned DST_N  = 1 << DST_AW;
   localparam int          BUDGET = 8000;

   logic              clk;
   logic              rst;
   logic              ce;
   logic              start;
   logic [SRC_AW-1:0] src_base;
   logic [DST_AW-1:0] dst_base;
   logic              halt_req;
   logic              halt_ack;
   logic [SRC_AW-1:0] src_addr;
   logic              src_ce;
   logic [7:0]        src_d;
   logic [DST_AW-1:0] dst_addr;
   logic [7:0]        dst_d;
   logic              dst_we;
   logic              busy;
   logic              done;

   dkong_obj_dma #(.SRC_AW(SRC_AW), .DST_AW(DST_AW), .LEN(LEN)) dut (
      .I_CLK      (clk),
      .I_RST      (rst),
      .I_CE       (ce),
      .I_START    (start),
      .I_SRC_BASE (src_base),
      .I_DST_BASE (dst_base),
      .O_HALT_REQ (halt_req),
      .I_HALT_ACK (halt_ack),
      .O_SRC_ADDR (src_addr),
      .O_SRC_CE   (src_ce),
      .I_SRC_D    (src_d),
      .O_DST_ADDR (dst_addr),
      .O_DST_D    (dst_d),
      .O_DST_WE   (dst_we),
      .O_BUSY     (busy),
      .O_DONE     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source work RAM: registered read on CE edges, output zero after a CE edge without a read
   logic [7:0] src_mem [SRC_N];
   logic [7:0] src_q = 8'h00;
   assign src_d = src_q;
   always @(posedge clk) if (ce) src_q <= src_ce ? src_mem[src_addr] : 8'h00;

   int ce_cyc = 0;
   always @(posedge clk) if (ce) ce_cyc <= ce_cyc + 1;

   // Bench state
   int  total, bad;
   int  wr_cnt, done_cnt, stall_cnt, t0, last_done_cyc, cyc, phase, done0;
   bit  busy_seen, throttle, ack_rand, ce_at;
   bit  prev_ce, prev_rst, have_prev;
   logic [30:0] snap, snap_prev;
   logic [DST_AW+7:0] exp_q[$];
   logic [DST_AW+7:0] e;
   logic [7:0] dst_mem [DST_N];
   logic [7:0] mdl_dst [DST_N];
   logic [7:0] save_dst [DST_N];
   logic [SRC_AW-1:0] sb;
   logic [DST_AW-1:0] db;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Accept a start on the next CE edge and load the scoreboard with the copy it implies
   task automatic do_start(input logic [SRC_AW-1:0] s, input logic [DST_AW-1:0] d);
      logic [DST_AW-1:0] a;
      logic [7:0]        v;
      src_base  = s;
      dst_base  = d;
      start     = 1'b1;
      wr_cnt    = 0;
      stall_cnt = 0;
      busy_seen = 1'b0;
      done0     = done_cnt;
      for (int k = 0; k < 8; k++) begin
         t0    = ce_cyc;
         ce_at = ce;
         step();
         if (ce_at) break;
      end
      start = 1'b0;
      for (int i = 0; i < int'(LEN); i++) begin
         a = DST_AW'(int'(d) + i);
         v = src_mem[SRC_AW'(int'(s) + i)];
         exp_q.push_back({a, v});
         mdl_dst[a] = v;
      end
   endtask

   task automatic wait_wr(input int n);
      int k = 0;
      while (wr_cnt < n && k < BUDGET) begin step(); k++; end
      check("reached_write_index", wr_cnt >= n, 1);
   endtask

   task automatic check_dst(input string name);
      int mism = 0;
      for (int i = 0; i < int'(DST_N); i++) if (dst_mem[i] !== mdl_dst[i]) mism++;
      check(name, mism, 0);
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (!(done_cnt > done0 && !busy) && k < BUDGET) begin step(); k++; end
      check({name, "_finished"}, done_cnt > done0, 1);
      check({name, "_done_pulses"}, done_cnt - done0, 1);
      check({name, "_write_count"}, wr_cnt, LEN);
      check_dst({name, "_dst_contents"});
   endtask

   task automatic fill_random();
      for (int i = 0; i < int'(SRC_N); i++) src_mem[i] = 8'($urandom);
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; start = 1'b0; src_base = '0; dst_base = '0;
      halt_ack = 1'b0; throttle = 1'b0; ack_rand = 1'b0;
      total = 0; bad = 0; wr_cnt = 0; done_cnt = 0; stall_cnt = 0; t0 = 0;
      last_done_cyc = 0; busy_seen = 1'b0; have_prev = 1'b0; phase = 0; done0 = 0;
      for (int i = 0; i < int'(DST_N); i++) begin
         dst_mem[i] = 8'($urandom);
         mdl_dst[i] = dst_mem[i];
      end
      fill_random();

      fork
         // Clock-enable and random grant driver
         forever begin
            @(posedge clk);
            #1;
            ce = throttle ? (phase % 4 == 0) : 1'b1;
            phase++;
            if (ack_rand) halt_ack = ($urandom_range(0, 3) != 0);
         end
         // Monitor: stability on non-CE edges, timing, and scoreboard of writes
         forever begin
            @(negedge clk);
            snap = {halt_req, busy, done, src_addr, dst_addr, dst_d};
            if (have_prev && !prev_ce && !prev_rst && !rst)
               check("stable_over_non_ce_edge", snap, snap_prev);
            snap_prev = snap; prev_ce = ce; prev_rst = rst; have_prev = 1'b1;
            if (!rst && ce) begin
               cyc = ce_cyc - t0;
               if (busy && !busy_seen) begin
                  busy_seen = 1'b1;
                  check("busy_rise_cycle", cyc, 1);
                  check("halt_req_with_busy", halt_req, 1);
               end
               if (halt_req && !halt_ack) stall_cnt++;
               if (dst_we) begin
                  wr_cnt++;
                  if (exp_q.size() == 0) check("write_was_expected", 0, 1);
                  else begin
                     e = exp_q.pop_front();
                     check("wr_addr", dst_addr, e[DST_AW+7:8]);
                     check("wr_data", dst_d, e[7:0]);
                  end
                  dst_mem[dst_addr] = dst_d;
               end
               if (done) begin
                  done_cnt++;
                  last_done_cyc = cyc;
                  check("done_cycle", cyc, 3 + LEN + stall_cnt);
                  check("halt_low_at_done", halt_req, 0);
                  check("busy_at_done", busy, 1);
                  check("all_writes_before_done", exp_q.size(), 0);
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_halt_req", halt_req, 0);
      check("rst_src_ce", src_ce, 0);
      check("rst_dst_we", dst_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_src_addr", src_addr, 0);
      check("rst_dst_addr", dst_addr, 0);
      check("rst_dst_d", dst_d, 0);
      rst = 1'b0;
      step();

      // Basic copy, grant held, full-rate CE
      for (int i = 0; i < int'(SRC_N); i++) src_mem[i] = 8'(i) ^ 8'h5A;
      halt_ack = 1'b1;
      do_start(10'h000, 10'h000);
      wait_done("basic");
      check("basic_done_at_387", last_done_cyc, 387);

      // Both address spaces wrap
      fill_random();
      do_start(10'h3F8, 10'h3F0);
      wait_done("wrap");

      // Grant withdrawn for 5 cycles at write 100 and 1 cycle at write 200
      fill_random();
      do_start(SRC_AW'($urandom), DST_AW'($urandom));
      wait_wr(100);
      halt_ack = 1'b0;
      repeat (5) step();
      halt_ack = 1'b1;
      wait_wr(200);
      halt_ack = 1'b0;
      step();
      halt_ack = 1'b1;
      wait_done("stall");
      check("stall_done_delay_6", last_done_cyc, 3 + LEN + 6);

      // CE one cycle in four, then with a random grant as well
      throttle = 1'b1;
      fill_random();
      do_start(SRC_AW'($urandom), DST_AW'($urandom));
      wait_done("throttle");
      ack_rand = 1'b1;
      for (int r = 0; r < 2; r++) begin
         fill_random();
         do_start(SRC_AW'($urandom), DST_AW'($urandom));
         wait_done("throttle_rand_ack");
      end
      ack_rand = 1'b0;
      throttle = 1'b0;
      halt_ack = 1'b1;
      step();

      // Reset at write 50: outputs drop at once, partial copy stays
      fill_random();
      save_dst = mdl_dst;
      sb = SRC_AW'($urandom);
      db = DST_AW'($urandom);
      do_start(sb, db);
      wait_wr(50);
      rst = 1'b1;
      #1;
      check("midrst_halt_req", halt_req, 0);
      check("midrst_dst_we", dst_we, 0);
      check("midrst_busy", busy, 0);
      check("midrst_src_ce", src_ce, 0);
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
      mdl_dst = save_dst;
      for (int i = 0; i < 50; i++) mdl_dst[DST_AW'(int'(db) + i)] = src_mem[SRC_AW'(int'(sb) + i)];
      check_dst("midrst_partial_dst");
      step();
      do_start(SRC_AW'($urandom), DST_AW'($urandom));
      wait_done("after_reset");

      // Start pulse while busy is ignored
      fill_random();
      do_start(SRC_AW'($urandom), DST_AW'($urandom));
      wait_wr(10);
      src_base = SRC_AW'($urandom);
      dst_base = DST_AW'($urandom);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("start_while_busy");
      repeat (6) step();
      check("no_second_transfer", busy, 0);
      check("single_done_total", done_cnt - done0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
